// File: rtl/complex_accum_sequencer_pkg.sv
// Shared definitions for the complex accumulate sequencer: word widths,
// FSM state encoding and the layout of one buffered input element.
package complex_accum_sequencer_pkg;

    localparam int CPLX_W  = 64;
    localparam int PART_W  = 32;
    localparam int COUNT_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_OUTPUT = 2'd3;

    // Single-precision complex word: real part in the upper half.
    typedef struct packed {
        logic [PART_W-1:0] re;
        logic [PART_W-1:0] im;
    } cplx_t;

    // One buffered element as it sits in the input FIFO.
    typedef struct packed {
        logic  op;
        logic  last;
        cplx_t data;
    } elem_t;

    localparam int ELEM_W = $bits(elem_t);

endpackage

// File: rtl/complex_accum_sequencer_fifo.sv
// Small synchronous FIFO with full/empty flags and an occupancy count.
// Read data is the head entry (first-word fall-through); pushes into a
// full FIFO and pops from an empty one are ignored.
module sync_fifo_flags #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (occ_q == (AW+1)'(DEPTH));
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // Next pointer and occupancy values; pointers wrap since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state: pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage array; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/complex_accum_sequencer.sv
// Buffers complex elements and folds each vector into an accumulator
// through an external complex adder-subtractor, then presents the
// vector total, element count and timeout error on a valid/ready port.
module complex_accum_sequencer
    import complex_accum_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [CPLX_W-1:0]   in_data,
    input  logic                in_op,
    input  logic                in_last,
    output logic                in_ready,
    output logic                add_start,
    output logic                add_ce,
    output logic                add_op,
    output logic [CPLX_W-1:0]   add_A,
    output logic [CPLX_W-1:0]   add_B,
    input  logic [CPLX_W-1:0]   add_result,
    input  logic                add_finish,
    output logic                out_valid,
    output logic [CPLX_W-1:0]   out_data,
    output logic [COUNT_W-1:0]  out_count,
    output logic                out_err,
    input  logic                out_ready
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    // Element count saturates instead of wrapping on very long vectors.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

    logic [1:0]          state_q, state_d;
    logic                have_first_q, have_first_d;
    logic [CPLX_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                err_q, err_d;
    logic [CPLX_W-1:0]   b_q, b_d;
    logic                op_q, op_d;
    logic                last_q, last_d;
    logic [TMO_W-1:0]    wait_cnt_q, wait_cnt_d;

    elem_t               fifo_wdata;
    elem_t               fifo_rdata;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [OCC_W-1:0]    fifo_occ;

    assign fifo_wdata = '{op: in_op, last: in_last, data: in_data};
    assign in_ready   = (fifo_occ < OCC_W'(FIFO_DEPTH));
    assign fifo_push  = in_valid && !fifo_full;

    sync_fifo_flags #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ELEM_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .wdata     (fifo_wdata),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    // Adder operands come straight from registers that only move outside ISSUE/WAIT.
    assign add_start = (state_q == ST_ISSUE);
    assign add_ce    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign add_A     = acc_q;
    assign add_B     = b_q;
    assign add_op    = op_q;
    assign out_valid = (state_q == ST_OUTPUT);
    assign out_data  = acc_q;
    assign out_count = count_q;
    assign out_err   = err_q;

    // Sequencer: load first element, issue one add per further element, wait, report.
    always_comb begin
        state_d      = state_q;
        have_first_d = have_first_q;
        acc_d        = acc_q;
        count_d      = count_q;
        err_d        = err_q;
        b_d          = b_q;
        op_d         = op_q;
        last_d       = last_q;
        wait_cnt_d   = wait_cnt_q;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (!have_first_q) begin
                        // First element seeds the accumulator; its op is irrelevant.
                        acc_d        = fifo_rdata.data;
                        count_d      = COUNT_W'(1);
                        have_first_d = 1'b1;
                        if (fifo_rdata.last) begin
                            state_d = ST_OUTPUT;
                        end
                    end else begin
                        b_d     = fifo_rdata.data;
                        op_d    = fifo_rdata.op;
                        last_d  = fifo_rdata.last;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // A finish seen alongside start belongs to nothing we issued.
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (add_finish) begin
                    acc_d   = add_result;
                    count_d = sat_inc(count_q);
                    state_d = last_q ? ST_OUTPUT : ST_IDLE;
                end else if (wait_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    // Give up on the adder and report what was accumulated so far.
                    err_d   = 1'b1;
                    state_d = ST_OUTPUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + TMO_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    count_d      = '0;
                    err_d        = 1'b0;
                    have_first_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any in-flight add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            have_first_q <= 1'b0;
            acc_q        <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            b_q          <= '0;
            op_q         <= 1'b0;
            last_q       <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            have_first_q <= have_first_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            err_q        <= err_d;
            b_q          <= b_d;
            op_q         <= op_d;
            last_q       <= last_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_complex_accum_sequencer.sv
// Directed bench for complex_accum_sequencer with a fixed-latency model adder.
module tb_complex_accum_sequencer;

    localparam logic [63:0] C_1_2 = 64'h3F800000_40000000;
    localparam logic [63:0] C_3_1 = 64'h40400000_3F800000;
    localparam logic [63:0] C_3_3 = 64'h40400000_40400000;
    localparam logic [63:0] C_2_0 = 64'h40000000_00000000;
    localparam logic [63:0] C_1_0 = 64'h3F800000_00000000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_op;
    logic        in_last;
    logic        in_ready;
    logic        add_start;
    logic        add_ce;
    logic        add_op;
    logic [63:0] add_A;
    logic [63:0] add_B;
    logic [63:0] add_result;
    logic        add_finish;
    logic        out_valid;
    logic [63:0] out_data;
    logic [15:0] out_count;
    logic        out_err;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;

    complex_accum_sequencer #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_op      (in_op),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .add_start  (add_start),
        .add_ce     (add_ce),
        .add_op     (add_op),
        .add_A      (add_A),
        .add_B      (add_B),
        .add_result (add_result),
        .add_finish (add_finish),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_err    (out_err),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed single-precision results for the operand pairs used below.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic op);
        case ({op, a, b})
            {1'b0, 32'h3F800000, 32'h40400000}: return 32'h40800000;
            {1'b0, 32'h40000000, 32'h3F800000}: return 32'h40400000;
            {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {1'b0, 32'h40400000, 32'h3F800000}: return 32'h40800000;
            {1'b0, 32'h40800000, 32'h3F800000}: return 32'h40A00000;
            {1'b0, 32'h40A00000, 32'h3F800000}: return 32'h40C00000;
            {1'b0, 32'h00000000, 32'h00000000}: return 32'h00000000;
            {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
            {1'b1, 32'h40400000, 32'h40000000}: return 32'h3F800000;
            default:                            return 32'hFFFFFFFF;
        endcase
    endfunction

    // Model adder: result appears 5 cycles after start, finish held one cycle.
    int          lat_cnt = 0;
    logic [63:0] res_q = '0;
    logic        never_finish = 1'b0;
    assign add_finish = (lat_cnt == 1);
    assign add_result = res_q;

    always @(posedge clk) begin
        if (add_start && !never_finish) begin
            lat_cnt <= 5;
            res_q   <= {fadd(add_A[63:32], add_B[63:32], add_op), fadd(add_A[31:0], add_B[31:0], add_op)};
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
        end
        if (add_start) begin
            n_start <= n_start + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic op, input logic last);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_last  = last;
        while (!in_ready && g < 200) begin
            step();
            g++;
        end
        check("push_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int bound);
        int g;
        g = 0;
        while (!out_valid && g < bound) begin
            step();
            g++;
        end
        check(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int s0;
        int g;
        logic seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_add_start", 64'(add_start), 64'd0);
        check("rst_add_ce", 64'(add_ce), 64'd0);
        check("rst_add_op", 64'(add_op), 64'd0);
        check("rst_add_A", add_A, 64'd0);
        check("rst_add_B", add_B, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        rst = 1'b0;
        step();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Two-element add vector
        s0 = n_start;
        push(C_1_2, 1'b0, 1'b0);
        push(C_3_1, 1'b0, 1'b1);
        wait_out("add_out_timeout", 100);
        check("add_out_data", out_data, 64'h40800000_40400000);
        check("add_out_count", 64'(out_count), 64'd2);
        check("add_out_err", 64'(out_err), 64'd0);
        check("add_start_pulses", 64'(n_start - s0), 64'd1);
        release_out();

        // Subtract vector, operands held through WAIT
        push(C_3_3, 1'b0, 1'b0);
        push(C_1_2, 1'b1, 1'b1);
        g = 0;
        while (!(add_ce && !add_start) && g < 50) begin
            step();
            g++;
        end
        check("sub_wait_reached", 64'(add_ce && !add_start), 64'd1);
        check("sub_add_op", 64'(add_op), 64'd1);
        check("sub_add_A", add_A, C_3_3);
        check("sub_add_B", add_B, C_1_2);
        step();
        step();
        check("sub_add_op_held", 64'(add_op), 64'd1);
        check("sub_add_A_held", add_A, C_3_3);
        check("sub_add_B_held", add_B, C_1_2);
        wait_out("sub_out_timeout", 100);
        check("sub_out_data", out_data, 64'h40000000_3F800000);
        check("sub_out_count", 64'(out_count), 64'd2);
        release_out();

        // Single-element vector, left stalled for the back-pressure step
        s0 = n_start;
        push(C_2_0, 1'b0, 1'b1);
        wait_out("single_out_timeout", 50);
        check("single_out_data", out_data, C_2_0);
        check("single_out_count", 64'(out_count), 64'd1);
        check("single_no_start", 64'(n_start - s0), 64'd0);

        // Back-pressure: FIFO fills while the output is held
        for (int i = 0; i < 4; i++) begin
            push(C_1_0, 1'b0, 1'b0);
        end
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = C_1_0;
        in_op    = 1'b0;
        in_last  = 1'b0;
        repeat (16) step();
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_data_stable", out_data, C_2_0);
        check("bp_out_count_stable", 64'(out_count), 64'd1);
        release_out();
        check("bp_pop_cycle_ready", 64'(in_ready), 64'd0);
        push(C_1_0, 1'b0, 1'b0);
        push(C_1_0, 1'b0, 1'b1);
        wait_out("bp_out_timeout", 300);
        check("bp_out_data", out_data, 64'h40C00000_00000000);
        check("bp_out_count", 64'(out_count), 64'd6);
        check("bp_out_err", 64'(out_err), 64'd0);
        release_out();
        check("bp_in_ready_back", 64'(in_ready), 64'd1);

        // Adder never finishes: timeout after 64 WAIT cycles
        never_finish = 1'b1;
        push(C_1_2, 1'b0, 1'b0);
        push(C_3_1, 1'b0, 1'b1);
        g = 0;
        while (!add_start && g < 50) begin
            step();
            g++;
        end
        check("tmo_issue_seen", 64'(add_start), 64'd1);
        repeat (64) step();
        check("tmo_still_waiting", 64'(out_valid), 64'd0);
        check("tmo_still_ce", 64'(add_ce), 64'd1);
        step();
        check("tmo_out_valid", 64'(out_valid), 64'd1);
        check("tmo_out_err", 64'(out_err), 64'd1);
        check("tmo_out_data", out_data, C_1_2);
        check("tmo_out_count", 64'(out_count), 64'd1);
        release_out();
        never_finish = 1'b0;
        check("tmo_err_cleared", 64'(out_err), 64'd0);
        check("tmo_count_cleared", 64'(out_count), 64'd0);

        // Reset two cycles into an add; the late finish must be ignored
        push(C_1_2, 1'b0, 1'b0);
        push(C_3_1, 1'b0, 1'b1);
        g = 0;
        while (!add_start && g < 50) begin
            step();
            g++;
        end
        check("rw_issue_seen", 64'(add_start), 64'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        check("rw_out_valid", 64'(out_valid), 64'd0);
        check("rw_add_ce", 64'(add_ce), 64'd0);
        check("rw_add_start", 64'(add_start), 64'd0);
        check("rw_add_op", 64'(add_op), 64'd0);
        check("rw_add_A", add_A, 64'd0);
        check("rw_add_B", add_B, 64'd0);
        check("rw_out_data", out_data, 64'd0);
        check("rw_out_count", 64'(out_count), 64'd0);
        check("rw_out_err", 64'(out_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen_valid = seen_valid | out_valid;
        end
        check("rw_no_stray_valid", 64'(seen_valid), 64'd0);
        check("rw_in_ready", 64'(in_ready), 64'd1);
        check("rw_add_ce_idle", 64'(add_ce), 64'd0);

        // Normal operation resumes after reset
        push(C_1_2, 1'b0, 1'b0);
        push(C_3_1, 1'b0, 1'b1);
        wait_out("again_out_timeout", 100);
        check("again_out_data", out_data, 64'h40800000_40400000);
        check("again_out_count", 64'(out_count), 64'd2);
        check("again_out_err", 64'(out_err), 64'd0);
        release_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
